// File: rtl/uno_s_pkg.sv
// Shared constants for the countdown-timer tick chain.
package uno_s_pkg;

  localparam int CLK_HZ                   = 50_000_000;
  localparam int CYCLES_PER_100MS_DEFAULT = CLK_HZ / 10;
  localparam int TENTHS_WIDTH             = 4;
  localparam int SIM_CYCLES_PER_100MS     = 2;

endpackage

// File: rtl/uno_s_if.sv
// Enable / pulse / tenths bundle between the game controller and the tick generator.
interface uno_s_if;
  import uno_s_pkg::*;

  logic                    enable;
  logic                    uno_second;
  logic [TENTHS_WIDTH-1:0] count_ten_cien_ms;

  modport master (
    output enable,
    input  uno_second,
    input  count_ten_cien_ms
  );

  modport slave (
    input  enable,
    output uno_second,
    output count_ten_cien_ms
  );

endinterface

// File: rtl/uno_s_prescaler.sv
// Divides the clock into one-cycle 100 ms ticks while enabled; holds its count when paused.
module uno_s_prescaler #(
  parameter int CYCLES_PER_100MS = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick_100ms
);

  localparam int PW = (CYCLES_PER_100MS > 1) ? $clog2(CYCLES_PER_100MS) : 1;
  localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_100MS - 1);

  logic [PW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last  = (r_cnt == LAST);
  assign tick_100ms = enable && w_at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uno_s.sv
// One-second tick generator: counts 100 ms ticks and pulses uno_second once per enabled second.
module uno_s
  import uno_s_pkg::*;
#(
  parameter int CYCLES_PER_100MS  = CYCLES_PER_100MS_DEFAULT,
  parameter int TENTHS_PER_SECOND = 10
) (
  input  logic    clk,
  input  logic    rst,
  uno_s_if.slave  bus
);

  localparam logic [TENTHS_WIDTH-1:0] LAST_TENTH = TENTHS_WIDTH'(TENTHS_PER_SECOND - 1);

  logic                    w_tick_100ms;
  logic                    w_last_tenth;
  logic [TENTHS_WIDTH-1:0] r_tenths;
  logic                    r_uno_second;

  uno_s_prescaler #(
    .CYCLES_PER_100MS (CYCLES_PER_100MS)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .enable     (bus.enable),
    .tick_100ms (w_tick_100ms)
  );

  assign w_last_tenth = (r_tenths == LAST_TENTH);

  // The pulse lands on the same edge the tenths count wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tenths     <= '0;
      r_uno_second <= 1'b0;
    end else begin
      r_uno_second <= w_tick_100ms && w_last_tenth;
      if (w_tick_100ms) begin
        r_tenths <= w_last_tenth ? '0 : r_tenths + 1'b1;
      end
    end
  end

  assign bus.uno_second        = r_uno_second;
  assign bus.count_ten_cien_ms = r_tenths;

endmodule

// File: tb/tb_uno_s.sv
// Directed bench for uno_s with a 2-cycle prescaler and 10 tenths per second.
module tb_uno_s;
  import uno_s_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  uno_s_if u_if ();

  uno_s #(
    .CYCLES_PER_100MS  (SIM_CYCLES_PER_100MS),
    .TENTHS_PER_SECOND (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs change and outputs are read here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int exp_cnt, input int exp_sec);
    chk({tag, "_cnt"}, int'(u_if.count_ten_cien_ms), exp_cnt);
    chk({tag, "_sec"}, int'(u_if.uno_second), exp_sec);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int prev_sec;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    u_if.enable = 1'b0;

    // Reset with enable low
    step();
    step();
    chk_state("reset", 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_state("idle", 0, 0);
    end

    // Two full seconds of enabled time from the reset state
    u_if.enable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk_state("run", (i / 2) % 10, (i == 20 || i == 40) ? 1 : 0);
    end

    // Pause after 7 enabled edges, then resume
    for (int i = 1; i <= 7; i++) step();
    chk_state("pre_pause", 3, 0);
    u_if.enable = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_state("pause", 3, 0);
    end
    u_if.enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk_state("resume", ((7 + k) / 2) % 10, (k == 13) ? 1 : 0);
    end

    // Reset in the middle of a second
    for (int i = 1; i <= 12; i++) step();
    chk_state("pre_rst", 6, 0);
    rst = 1'b1;
    step();
    chk_state("mid_rst", 0, 0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_state("post_rst", (k / 2) % 10, (k == 20) ? 1 : 0);
    end

    // Drop enable during the pulse cycle
    u_if.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state("drop", 0, 0);
    end

    // Long run: 200 enabled edges
    u_if.enable = 1'b1;
    pulses     = 0;
    last_pulse = 0;
    prev_sec   = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (u_if.uno_second) begin
        pulses++;
        chk("long_spacing", i - last_pulse, 20);
        chk("long_width", prev_sec, 0);
        last_pulse = i;
      end
      prev_sec = int'(u_if.uno_second);
    end
    chk("long_pulses", pulses, 10);
    chk("long_last", last_pulse, 200);
    u_if.enable = 1'b0;
    step();
    chk_state("long_end", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
